// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU command sequencer.
// Holds the opcode values, the frame sync nibble, response status codes
// and the sequencer FSM state encoding.
package alu_pkg;

   localparam logic [3:0] OP_ADD = 4'h0;
   localparam logic [3:0] OP_SUB = 4'h1;
   localparam logic [3:0] OP_MUL = 4'h2;
   localparam logic [3:0] OP_DIV = 4'h3;

   localparam logic [3:0] SYNC = 4'h5;

   localparam logic [7:0] ST_OK    = 8'h01;
   localparam logic [7:0] ST_UNSUP = 8'h00;
   localparam logic [7:0] ST_DIVZ  = 8'h02;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_GET_A   = 3'd1,
      S_GET_B   = 3'd2,
      S_ISSUE   = 3'd3,
      S_CAPTURE = 3'd4,
      S_SEND    = 3'd5
   } state_t;

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// alu_cmd_sequencer_if: bundles the command byte stream (rx_*), the
// arithmetic unit issue/result bus, the response byte stream (tx_*) and
// the busy/err status lines.
//   master : host link + arithmetic unit side
//   slave  : the sequencer
interface alu_cmd_sequencer_if #(
   parameter int unsigned WIDTH = 16
);
   logic [7:0]              rx_data;
   logic                    rx_valid;
   logic                    rx_ready;
   logic signed [WIDTH-1:0] a;
   logic signed [WIDTH-1:0] b;
   logic [3:0]              alu_fun;
   logic                    arith_en;
   logic [2*WIDTH-1:0]      res_in;
   logic                    res_flag;
   logic [7:0]              tx_data;
   logic                    tx_valid;
   logic                    tx_ready;
   logic                    busy;
   logic                    err;

   modport master (
      output rx_data, rx_valid, res_in, res_flag, tx_ready,
      input  rx_ready, a, b, alu_fun, arith_en, tx_data, tx_valid, busy, err
   );

   modport slave (
      input  rx_data, rx_valid, res_in, res_flag, tx_ready,
      output rx_ready, a, b, alu_fun, arith_en, tx_data, tx_valid, busy, err
   );
endinterface

// File: rtl/alu_rsp_serializer.sv
// alu_rsp_serializer: loads a status byte plus a 2*WIDTH result and shifts
// them out MSB first as 1 + 2*NB bytes under valid/ready.
//   i_load     : capture i_status/i_result and start sending
//   i_tx_ready : downstream accepts the current byte
//   o_tx_data  : current byte, held while stalled
//   o_tx_valid : byte available
//   o_last_c   : final byte accepted this cycle (combinational)
module alu_rsp_serializer #(
   parameter int unsigned WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_load,
   input  logic [7:0]           i_status,
   input  logic [2*WIDTH-1:0]   i_result,
   input  logic                 i_tx_ready,
   output logic [7:0]           o_tx_data,
   output logic                 o_tx_valid,
   output logic                 o_last_c
);
   localparam int unsigned NBYTES = 1 + 2 * (WIDTH / 8);
   localparam int unsigned TOT_W  = 8 + 2 * WIDTH;
   localparam int unsigned LEFT_W = $clog2(NBYTES + 1);

   logic [TOT_W-1:0]  r_shift;
   logic [LEFT_W-1:0] r_left;
   logic              r_valid;
   logic              w_fire;

   assign w_fire     = r_valid & i_tx_ready;
   assign o_last_c   = w_fire & (r_left == LEFT_W'(1));
   assign o_tx_data  = r_shift[TOT_W-1 -: 8];
   assign o_tx_valid = r_valid;

   // Shift register advances only on an accepted byte, so data is stable under stall
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_shift <= '0;
         r_left  <= '0;
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_shift <= {i_status, i_result};
         r_left  <= LEFT_W'(NBYTES);
         r_valid <= 1'b1;
      end else if (w_fire) begin
         r_left <= r_left - LEFT_W'(1);
         if (r_left == LEFT_W'(1)) begin
            r_valid <= 1'b0;
         end else begin
            r_shift <= {r_shift[TOT_W-9:0], 8'h00};
         end
      end
   end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: receives opcode/A/B command frames over a byte stream,
// issues one operation to the registered arithmetic unit, captures its
// result and returns status + result over a response byte stream.
//   clk, rst : clock, async active-low reset
//   bus      : slave side of alu_cmd_sequencer_if (rx/tx streams, ALU bus,
//              busy, err)
module alu_cmd_sequencer
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic                clk,
   input  logic                rst,
   alu_cmd_sequencer_if.slave  bus
);
   localparam int unsigned NB    = WIDTH / 8;
   localparam int unsigned CNT_W = (NB > 1) ? $clog2(NB) : 1;

   state_t                  r_state;
   logic [CNT_W-1:0]        r_cnt;
   logic signed [WIDTH-1:0] r_a;
   logic signed [WIDTH-1:0] r_b;
   logic [3:0]              r_fun;
   logic                    r_arith_en;
   logic                    r_rx_ready;
   logic                    r_busy;
   logic                    r_err;
   logic                    r_divz;

   logic                    w_rx_fire;
   logic                    w_cnt_last;
   logic signed [WIDTH-1:0] w_a_shift;
   logic signed [WIDTH-1:0] w_b_shift;
   logic                    w_divz;
   logic                    w_ld;
   logic [7:0]              w_status;
   logic [2*WIDTH-1:0]      w_result;
   logic                    w_tx_last;

   assign w_rx_fire  = bus.rx_valid & r_rx_ready;
   assign w_cnt_last = (r_cnt == CNT_W'(NB - 1));
   assign w_a_shift  = WIDTH'({r_a, bus.rx_data});
   assign w_b_shift  = WIDTH'({r_b, bus.rx_data});
   // Decided on the last B byte so arith_en can be suppressed from its first cycle
   assign w_divz     = (r_fun == OP_DIV) && (w_b_shift == '0);

   // Divide-by-zero loads from ISSUE; normal results load from CAPTURE
   assign w_ld     = ((r_state == S_ISSUE) && r_divz) || (r_state == S_CAPTURE);
   assign w_status = (r_state == S_CAPTURE) ? {7'b0, bus.res_flag} : ST_DIVZ;
   assign w_result = (r_state == S_CAPTURE) ? bus.res_in : '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_a        <= '0;
         r_b        <= '0;
         r_fun      <= '0;
         r_arith_en <= 1'b0;
         r_rx_ready <= 1'b0;
         r_busy     <= 1'b0;
         r_err      <= 1'b0;
         r_divz     <= 1'b0;
      end else begin
         r_err      <= 1'b0;
         r_arith_en <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_rx_ready <= 1'b1;
               if (w_rx_fire) begin
                  if (bus.rx_data[7:4] == SYNC) begin
                     r_fun   <= bus.rx_data[3:0];
                     r_cnt   <= '0;
                     r_busy  <= 1'b1;
                     r_state <= S_GET_A;
                  end else begin
                     r_err <= 1'b1;
                  end
               end
            end
            S_GET_A: begin
               if (w_rx_fire) begin
                  r_a <= w_a_shift;
                  if (w_cnt_last) begin
                     r_cnt   <= '0;
                     r_state <= S_GET_B;
                  end else begin
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end
            end
            S_GET_B: begin
               if (w_rx_fire) begin
                  r_b <= w_b_shift;
                  if (w_cnt_last) begin
                     r_cnt      <= '0;
                     r_rx_ready <= 1'b0;
                     r_divz     <= w_divz;
                     r_arith_en <= ~w_divz;
                     r_state    <= S_ISSUE;
                  end else begin
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end
            end
            S_ISSUE: begin
               r_state <= r_divz ? S_SEND : S_CAPTURE;
            end
            S_CAPTURE: begin
               r_state <= S_SEND;
            end
            S_SEND: begin
               if (w_tx_last) begin
                  r_rx_ready <= 1'b1;
                  r_busy     <= 1'b0;
                  r_state    <= S_IDLE;
               end
            end
            default: begin
               r_rx_ready <= 1'b1;
               r_busy     <= 1'b0;
               r_state    <= S_IDLE;
            end
         endcase
      end
   end

   alu_rsp_serializer #(.WIDTH(WIDTH)) u_rsp (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_ld),
      .i_status   (w_status),
      .i_result   (w_result),
      .i_tx_ready (bus.tx_ready),
      .o_tx_data  (bus.tx_data),
      .o_tx_valid (bus.tx_valid),
      .o_last_c   (w_tx_last)
   );

   assign bus.rx_ready = r_rx_ready;
   assign bus.a        = r_a;
   assign bus.b        = r_b;
   assign bus.alu_fun  = r_fun;
   assign bus.arith_en = r_arith_en;
   assign bus.busy     = r_busy;
   assign bus.err      = r_err;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: directed frames with hand-computed responses,
// checked by immediate assertions; includes a registered arithmetic unit stub.
module tb_alu_cmd_sequencer;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;
   int   n_arith = 0;
   int   n_errp = 0;
   int   snap;

   alu_cmd_sequencer_if #(.WIDTH(16)) bus ();

   alu_cmd_sequencer #(.WIDTH(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Registered arithmetic unit stub: result and flag one edge after arith_en
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.res_in   <= '0;
         bus.res_flag <= 1'b0;
      end else if (bus.arith_en) begin
         bus.res_flag <= (bus.alu_fun < 4'h4);
         case (bus.alu_fun)
            4'h0: bus.res_in <= bus.a + bus.b;
            4'h1: bus.res_in <= bus.a - bus.b;
            4'h2: bus.res_in <= bus.a * bus.b;
            4'h3: bus.res_in <= (bus.b != 0) ? bus.a / bus.b : '0;
            default: bus.res_in <= '0;
         endcase
      end
   end

   always @(posedge clk) begin
      if (bus.arith_en) n_arith++;
      if (bus.err) n_errp++;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] d);
      int k = 0;
      @(negedge clk);
      bus.rx_data  = d;
      bus.rx_valid = 1'b1;
      while (!bus.rx_ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      check("rx_ready_wait", 64'(bus.rx_ready), 64'd1);
      @(posedge clk);
      #1;
      bus.rx_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b);
      send_byte(op);
      send_byte(a[15:8]);
      send_byte(a[7:0]);
      send_byte(b[15:8]);
      send_byte(b[7:0]);
   endtask

   task automatic recv_rsp(input logic [39:0] exp, input bit stall, input string tag);
      int         got = 0;
      int         cyc = 0;
      int         i = 0;
      bit         stalled = 1'b0;
      logic [7:0] held = '0;
      logic [7:0] eb;
      while (got < 5 && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (stalled) check({tag, "_stall_hold"}, 64'(bus.tx_data), 64'(held));
         bus.tx_ready = stall ? (i % 3 == 0) : 1'b1;
         i++;
         if (bus.tx_valid && bus.tx_ready) begin
            eb = exp[39 - 8*got -: 8];
            check($sformatf("%s_byte%0d", tag, got), 64'(bus.tx_data), 64'(eb));
            got++;
            stalled = 1'b0;
         end else if (bus.tx_valid) begin
            stalled = 1'b1;
            held    = bus.tx_data;
         end
      end
      check({tag, "_count"}, 64'(got), 64'd5);
      @(posedge clk);
      #1;
      bus.tx_ready = 1'b0;
      check({tag, "_busy_end"}, 64'(bus.busy), 64'd0);
      check({tag, "_rdy_end"}, 64'(bus.rx_ready), 64'd1);
      check({tag, "_txv_end"}, 64'(bus.tx_valid), 64'd0);
   endtask

   initial begin
      bus.rx_data  = '0;
      bus.rx_valid = 1'b0;
      bus.tx_ready = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_rx_ready", 64'(bus.rx_ready), 64'd0);
      check("rst_outs", {bus.a, bus.b, 4'(bus.alu_fun), bus.arith_en, bus.busy, bus.err, bus.tx_valid, bus.tx_data},
            64'd0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("rel_rx_ready", 64'(bus.rx_ready), 64'd1);

      // ADD 3+4 with explicit issue/capture timing
      snap = n_arith;
      send_frame(8'h50, 16'h0003, 16'h0004);
      check("add_arith_en_N", 64'(bus.arith_en), 64'd1);
      check("add_rx_ready_N", 64'(bus.rx_ready), 64'd0);
      check("add_busy", 64'(bus.busy), 64'd1);
      @(posedge clk); #1;
      check("add_arith_en_N1", 64'(bus.arith_en), 64'd0);
      check("add_txv_N1", 64'(bus.tx_valid), 64'd0);
      @(posedge clk); #1;
      check("add_txv_N2", 64'(bus.tx_valid), 64'd1);
      check("add_status_N2", 64'(bus.tx_data), 64'h01);
      recv_rsp(40'h01_0000_0007, 1'b0, "add");
      check("add_arith_cnt", 64'(n_arith - snap), 64'd1);

      // SUB 5-9
      send_frame(8'h51, 16'h0005, 16'h0009);
      recv_rsp(40'h01_FFFF_FFFC, 1'b0, "sub");

      // MUL -2*3
      send_frame(8'h52, 16'hFFFE, 16'h0003);
      check("mul_fun", 64'(bus.alu_fun), 64'h2);
      recv_rsp(40'h01_FFFF_FFFA, 1'b0, "mul");

      // DIV by zero: no issue strobe, response one cycle earlier
      snap = n_arith;
      send_frame(8'h53, 16'h0008, 16'h0000);
      check("divz_arith_en_N", 64'(bus.arith_en), 64'd0);
      @(posedge clk); #1;
      check("divz_txv_N1", 64'(bus.tx_valid), 64'd1);
      check("divz_status_N1", 64'(bus.tx_data), 64'h02);
      recv_rsp(40'h02_0000_0000, 1'b0, "divz");
      check("divz_arith_cnt", 64'(n_arith - snap), 64'd0);
      check("divz_a_held", 64'($unsigned(bus.a)), 64'h0008);

      // Bad sync byte, then a good ADD frame
      snap = n_errp;
      send_byte(8'h33);
      check("bad_err_pulse", 64'(bus.err), 64'd1);
      check("bad_busy", 64'(bus.busy), 64'd0);
      @(posedge clk); #1;
      check("bad_err_clear", 64'(bus.err), 64'd0);
      send_frame(8'h50, 16'h0001, 16'h0002);
      recv_rsp(40'h01_0000_0003, 1'b0, "after_bad");
      check("bad_err_cnt", 64'(n_errp - snap), 64'd1);

      // Unsupported opcode: flag clear gives status 00
      send_frame(8'h57, 16'h0011, 16'h0022);
      recv_rsp(40'h00_0000_0000, 1'b0, "unsup");

      // Stalled response with tx_ready pattern 1,0,0,1,...
      send_frame(8'h50, 16'h1234, 16'h0011);
      recv_rsp(40'h01_0000_1245, 1'b1, "stall");

      // Reset mid-frame, then a full frame
      send_byte(8'h50);
      send_byte(8'h00);
      send_byte(8'h01);
      check("mid_a_partial", 64'($unsigned(bus.a)), 64'h0001);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("mid_rst_rx_ready", 64'(bus.rx_ready), 64'd0);
      check("mid_rst_outs", {bus.a, bus.b, 4'(bus.alu_fun), bus.arith_en, bus.busy, bus.err, bus.tx_valid, bus.tx_data},
            64'd0);
      @(negedge clk);
      rst = 1'b1;
      send_frame(8'h51, 16'h0100, 16'h0001);
      recv_rsp(40'h01_0000_00FF, 1'b0, "post_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Byte-stream front end for the registered arithmetic unit. Receives command frames (opcode, operand A, operand B) over a valid/ready byte interface, drives one operation into the arithmetic unit, captures the registered result and flag, and returns a status-plus-result response over a second valid/ready byte interface. It sits between the host link and the arithmetic unit, acting as the initiator for that unit.

## Interface
- WIDTH, 16, operand width; must be a multiple of 8; NB = WIDTH/8 bytes per operand.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- rx_data  in  8  command byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  sequencer accepts a byte; a transfer occurs when rx_valid && rx_ready at the clock edge.
- a  out  WIDTH  signed operand A to the arithmetic unit.
- b  out  WIDTH  signed operand B to the arithmetic unit.
- alu_fun  out  4  operation select to the arithmetic unit.
- arith_en  out  1  one-cycle issue strobe to the arithmetic unit.
- res_in  in  2*WIDTH  registered result from the arithmetic unit.
- res_flag  in  1  registered valid flag from the arithmetic unit.
- tx_data  out  8  response byte.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  downstream accepts the response byte.
- busy  out  1  high in every state except IDLE.
- err  out  1  one-cycle pulse on a rejected opcode byte.

## Operation
- Frame: opcode byte, then A as NB bytes MSB first, then B as NB bytes MSB first. Opcode bits [7:4] must equal SYNC = 4'h5; bits [3:0] carry alu_fun.
- States: IDLE -> GET_A -> GET_B -> ISSUE -> CAPTURE -> SEND -> IDLE.
- IDLE: rx_ready=1. On an accepted byte with a good SYNC, latch alu_fun and go to GET_A. On a bad SYNC, drop the byte, pulse err, and stay in IDLE.
- GET_A / GET_B: rx_ready=1. Shift in bytes; a byte counter counts 0..NB-1 and wraps to 0 on the state change. The last B byte moves to ISSUE.
- ISSUE: rx_ready=0 and arith_en=1 for exactly one cycle. Exception: when alu_fun=4'h3 and b=0, arith_en stays 0, the status register is set to 0x02, the result register is set to 0, and the FSM goes directly to SEND.
- CAPTURE: latch res_in into the result register. Latch the status as {7'b0, res_flag}, so it is 0x01 for opcodes 0-3 and 0x00 for opcodes 4-15.
- SEND: emit 1 + 2*NB bytes: the status byte, then the result MSB first. tx_data stays stable while tx_valid && !tx_ready. After the last accepted byte, return to IDLE.
- a, b and alu_fun are registers. They hold their values until the next frame overwrites them. The operand registers load progressively, byte by byte, during GET_A and GET_B.
- rx_valid in ISSUE, CAPTURE or SEND is ignored because rx_ready=0. No byte is lost, since the sender must hold the byte.
- Reset asserted mid-frame or mid-response: immediate return to IDLE. The partial frame is discarded and no response is sent.

## Timing
- Reset values: rx_ready=0 while rst=0 and 1 in the first cycle after release. a, b, alu_fun, arith_en, tx_data, tx_valid, busy and err are all 0.
- With the last B byte accepted at edge N:
  - arith_en is high during cycle N..N+1.
  - The arithmetic unit registers the result at edge N+1.
  - The result is captured at edge N+2.
  - tx_valid first rises after edge N+2.
- Divide-by-zero path: tx_valid rises after edge N+1.
- Response length with tx_ready tied high: 1 + 2*NB cycles, which is 5 for WIDTH=16.
- Back-to-back frames: a new opcode byte is accepted no earlier than the cycle after the last response byte is accepted.

## Structure
- Shared package alu_pkg holds:
  - opcode localparams: OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_DIV=3;
  - SYNC=4'h5;
  - status codes: ST_OK=8'h01, ST_UNSUP=8'h00, ST_DIVZ=8'h02;
  - the FSM state enum.
- One natural sub-module, alu_rsp_serializer: it loads the status and the 2*WIDTH result, then shifts the bytes out under the tx valid/ready rule. The parent holds the FSM, the operand assembly and the byte counter.

## Test plan
- Frame 0x50, 0x00, 0x03, 0x00, 0x04 (ADD 3+4) -> one arith_en pulse; response 01 00 00 00 07.
- Frame 0x51, 0x00, 0x05, 0x00, 0x09 (SUB) -> response 01 FF FF FF FC.
- Frame 0x52, 0xFF, 0xFE, 0x00, 0x03 (MUL -2*3) -> response 01 FF FF FF FA.
- Frame 0x53, 0x00, 0x08, 0x00, 0x00 (DIV by 0) -> arith_en never asserted; response 02 00 00 00 00.
- Opcode byte 0x33, then a valid ADD frame -> err pulses once, busy stays 0 for the bad byte, and the ADD frame completes normally.
- Response phase with tx_ready toggling 1,0,0,1,... -> tx_data stable while stalled; all 5 bytes delivered in order.
- rst pulsed low after 3 bytes of a frame -> all outputs return to reset values; the next full frame produces the correct response.
